button_scheduler: RTL and testbench

BUTTON_SCHEDULER -- requirements
Module: button_scheduler

---
 rtl/button_scheduler.sv | 142 ++++++++++++++
 tb/tb_button_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_scheduler.sv
// Four-button front end: synchronise, debounce, then arbitrate press and
// auto-repeat events onto a single valid/ready event channel.
// Legal ranges: DB_CYCLES 2..65535, HOLD_CYCLES and REPEAT_CYCLES 2..2^24-1.
module button_scheduler #(
  parameter int unsigned DB_CYCLES     = 30000,
  parameter int unsigned HOLD_CYCLES   = 3000000,
  parameter int unsigned REPEAT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  output logic       evt_repeat,
  output logic [3:0] level
);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  // Repeat fires on the edge the hold counter reaches threshold-1, so the
  // decision compares the pre-increment value against threshold-2.
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 2);
  localparam logic [23:0] REP_LAST  = 24'(REPEAT_CYCLES - 2);

  state_t      state;
  logic [3:0]  sync1, sync2;
  logic [15:0] db_cnt [4];
  logic [3:0]  db_hit;
  logic [3:0]  rise;
  logic [3:0]  pending;
  logic [3:0]  grant_mask;
  logic [1:0]  grant_id;
  logic [23:0] hold_cnt;
  logic        rep_phase;

  // Two-flop synchroniser on the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce expiry and rising-edge detection of the debounced levels
  always_comb begin
    db_hit = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      db_hit[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
    end
    rise = db_hit & ~level;
  end

  // Per-button disagreement counters; level flips once the disagreement persists
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_hit[i]) begin
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Lowest-index pending button wins the grant from IDLE
  always_comb begin
    grant_id   = 2'd0;
    grant_mask = '0;
    if (state == IDLE) begin
      for (int i = 3; i >= 0; i--) begin
        if (pending[i]) begin
          grant_id   = 2'(i);
          grant_mask = 4'b0001 << i;
        end
      end
    end
  end

  // Sticky press flags; a new press on the same edge as a grant survives
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~grant_mask) | rise;
  end

  // Arbiter: present press events, then auto-repeat while the button stays held
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      hold_cnt   <= '0;
      rep_phase  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            evt_valid  <= 1'b1;
            evt_id     <= grant_id;
            evt_repeat <= 1'b0;
            rep_phase  <= 1'b0;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (evt_ready) begin
            evt_valid  <= 1'b0;
            evt_repeat <= 1'b0;
            hold_cnt   <= '0;
            state      <= level[evt_id] ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!level[evt_id] || (|pending)) begin
            state <= IDLE;
          end else if (hold_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
            evt_valid  <= 1'b1;
            evt_repeat <= 1'b1;
            rep_phase  <= 1'b1;
            state      <= PRESENT;
          end else begin
            hold_cnt <= hold_cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_scheduler.sv
// Bench for button_scheduler with short timing parameters.
module tb_button_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] level;

  button_scheduler #(
    .DB_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_repeat(evt_repeat),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic       rep;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] ids;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   t0 = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every handshake pops and compares one expected event
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!evt_valid && evt_repeat !== 1'b0) begin
        errors++;
        $display("FAIL repeat_idle: evt_repeat=%0b while evt_valid=0 at rel cycle %0d", evt_repeat, cyc - t0);
      end
      if (evt_valid && evt_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: id=%0d rep=%0b at rel cycle %0d, none expected", evt_id, evt_repeat, cyc - t0);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (evt_id !== e.id || evt_repeat !== e.rep || (cyc - t0) != e.cyc) begin
            errors++;
            $display("FAIL event: got id=%0d rep=%0b cycle=%0d, expected id=%0d rep=%0b cycle=%0d",
                     evt_id, evt_repeat, cyc - t0, e.id, e.rep, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic rep, input int c);
    exp_t e;
    e.id = id;
    e.rep = rep;
    e.cyc = c;
    q.push_back(e);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{mask: 4'b0100, n: 1, ids: 8'b00_00_00_10};
    vecs[1] = '{mask: 4'b1010, n: 2, ids: 8'b00_00_11_01};
    vecs[2] = '{mask: 4'b0001, n: 1, ids: 8'b00_00_00_00};
    vecs[3] = '{mask: 4'b1111, n: 4, ids: 8'b11_10_01_00};
    vecs[4] = '{mask: 4'b1001, n: 2, ids: 8'b00_00_11_00};

    btn = '0;
    evt_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_id", 32'(evt_id), 32'd0);
    chk("reset_repeat", 32'(evt_repeat), 32'd0);
    rst = 1'b0;
    tick();

    // Simultaneous presses: lowest index first, then one every 3 cycles
    for (int v = 0; v < 5; v++) begin
      tick();
      t0 = cyc;
      btn = vecs[v].mask;
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].ids[2*k +: 2], 1'b0, 7 + 3*k);
      for (int c = 1; c < 60; c++) begin
        tick();
        if (c == 5) chk("level_before", 32'(level), 32'd0);
        if (c == 6) chk("level_at_db", 32'(level), 32'(vecs[v].mask));
        if (c == 20) btn = '0;
      end
      chk("vec_drain", 32'(q.size()), 32'd0);
    end

    // Bounce shorter than the debounce window never reaches level
    tick();
    t0 = cyc;
    for (int c = 0; c < 30; c++) begin
      btn[0] = ((c / 3) % 2) == 0;
      if (c > 0) chk("bounce_level", 32'(level[0]), 32'd0);
      tick();
    end
    btn = '0;
    repeat (10) tick();
    chk("bounce_final", 32'(level), 32'd0);

    // Held button: first repeat 20 after handshake, then every 8
    tick();
    t0 = cyc;
    btn = 4'b0010;
    push(2'd1, 1'b0, 7);
    for (int k = 0; k < 6; k++) push(2'd1, 1'b1, 27 + 8*k);
    for (int c = 1; c < 100; c++) begin
      tick();
      if (c == 67) btn = '0;
    end
    chk("repeat_drain", 32'(q.size()), 32'd0);

    // Backpressure: presented event frozen, second press queued behind it
    tick();
    t0 = cyc;
    btn = 4'b0010;
    evt_ready = 1'b0;
    push(2'd1, 1'b0, 17);
    push(2'd0, 1'b0, 20);
    for (int c = 1; c < 60; c++) begin
      tick();
      if (c == 8) btn = 4'b0011;
      if (c >= 7 && c <= 16) chk("stall_hold", 32'({evt_valid, evt_id, evt_repeat}), 32'b1_01_0);
      if (c == 17) evt_ready = 1'b1;
      if (c == 25) btn = '0;
    end
    chk("stall_drain", 32'(q.size()), 32'd0);

    // Reset during PRESENT, button still held: re-debounce from scratch
    tick();
    t0 = cyc;
    btn = 4'b0100;
    evt_ready = 1'b0;
    push(2'd2, 1'b0, 17);
    for (int c = 1; c < 50; c++) begin
      tick();
      if (c == 7) chk("pre_rst_valid", 32'(evt_valid), 32'd1);
      if (c == 9) rst = 1'b1;
      if (c == 10) begin
        rst = 1'b0;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        evt_ready = 1'b1;
      end
      if (c == 15) chk("redb_before", 32'(level[2]), 32'd0);
      if (c == 16) chk("redb_at", 32'(level[2]), 32'd1);
      if (c == 25) btn = '0;
    end
    chk("rst_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
